// File: rtl/ps2_receiver_if.sv
// Purpose : consumer-side bundle of ps2_receiver (FIFO read port, status, sticky flags).
// Latency : n/a (signal bundle only).
// Backpressure: none; the consumer pops with rd, and frames arriving at a full FIFO are dropped.
// Ports   : rd/clr_err (consumer -> receiver); data/valid/count/busy/parity_err/frame_err/overflow
//           (receiver -> consumer). master = receiver side, slave = consumer side.
interface ps2_receiver_if #(
    parameter int FIFO_AW = 3
);
    logic               rd;
    logic               clr_err;
    logic [7:0]         data;
    logic               valid;
    logic [FIFO_AW:0]   count;
    logic               busy;
    logic               parity_err;
    logic               frame_err;
    logic               overflow;

    modport master (
        input  rd, clr_err,
        output data, valid, count, busy, parity_err, frame_err, overflow
    );

    modport slave (
        output rd, clr_err,
        input  data, valid, count, busy, parity_err, frame_err, overflow
    );
endinterface

// File: rtl/ps2_receiver.sv
// Purpose : PS/2 device-to-host receiver: sync + glitch filter, 11-bit frame FSM, odd parity
//           check, frame timeout, first-word-fall-through byte FIFO with sticky error flags.
// Latency : good byte visible on data/valid 2 clk after the filtered stop-bit falling edge.
// Backpressure: none toward the pad; a good byte arriving at a full FIFO (no pop) is dropped
//           and flags overflow.
// Ports   : clk, reset (sync, active-high); ps2_clk_in/ps2_dat_in raw pad inputs;
//           bus (master modport) carries rd, clr_err, data, valid, count, busy and error flags.
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_AW        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2_clk_in,
    input  logic             ps2_dat_in,
    ps2_receiver_if.master   bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // ---------------- 2-FF synchronizers, preset to bus idle level ----------------
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_in;
            dat_s2_q <= dat_s1_q;
        end
    end

    // ---------------- PS/2 clock glitch filter ----------------
    // filt_cnt_q counts consecutive samples differing from the filtered level; the level
    // flips on the FILTER_LEN-th such sample, and any agreeing sample restarts the count.
    logic          filt_clk_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_flip;
    logic          fall_edge;

    assign filt_flip = (clk_s2_q != filt_clk_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
    // Edge is flagged in the cycle the filtered level is about to drop, so the data bit
    // sampled alongside it comes from the same synchronizer stage.
    assign fall_edge = filt_flip && filt_clk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s2_q == filt_clk_q) begin
            filt_cnt_q <= '0;
        end else if (filt_flip) begin
            filt_clk_q <= clk_s2_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    // ---------------- Frame FSM with timeout ----------------
    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic          push_q;      // one-cycle push of shift_q into the FIFO
    logic          par_set_q;
    logic          frm_set_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            push_q    <= 1'b0;
            par_set_q <= 1'b0;
            frm_set_q <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            par_set_q <= 1'b0;
            frm_set_q <= 1'b0;

            if (state_q == ST_IDLE || fall_edge) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end

            if (state_q != ST_IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                shift_q   <= '0;
                frm_set_q <= 1'b1;
            end else if (fall_edge) begin
                case (state_q)
                    ST_IDLE: begin
                        // A high data bit here is line noise or a tail of an aborted frame.
                        if (!dat_s2_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= ST_STOP;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        if (!(^shift_q ^ par_q)) begin
                            par_set_q <= 1'b1;
                        end else if (!dat_s2_q) begin
                            frm_set_q <= 1'b1;
                        end else begin
                            push_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- FWFT FIFO ----------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               pop, full, wr_en, ovf_set;

    assign pop     = bus.rd && (cnt_q != '0);
    assign full    = (cnt_q == (FIFO_AW + 1)'(DEPTH));
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign wr_en   = push_q && (!full || pop);
    assign ovf_set = push_q && full && !pop;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!wr_en && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // ---------------- Sticky flags: a new error wins over a same-cycle clear ----------------
    logic parity_err_q, frame_err_q, overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            parity_err_q <= (parity_err_q & ~bus.clr_err) | par_set_q;
            frame_err_q  <= (frame_err_q  & ~bus.clr_err) | frm_set_q;
            overflow_q   <= (overflow_q   & ~bus.clr_err) | ovf_set;
        end
    end

    // Empty FIFO reads as zero so data is defined out of reset.
    assign bus.data       = (cnt_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.valid      = (cnt_q != '0);
    assign bus.count      = cnt_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
endmodule
